// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the image loader.
// master = byte source / memory side, slave = loader.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian program image into instruction memory
// and holds the core in reset until the whole image has been written.
module imem_loader #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_written
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_in_ready;
  logic               r_wr_en;
  logic [31:0]        r_wr_addr;
  logic [31:0]        r_wr_data;
  logic               r_cpu_reset;
  logic               r_done;
  logic               r_error;
  logic [LEN_W-1:0]   r_words_written;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_word_cnt;
  logic [1:0]         r_byte_cnt;
  logic [31:0]        r_word;
  logic [TO_W-1:0]    r_to;

  logic               w_hs;
  logic               w_counting;
  logic               w_timeout;
  logic [LEN_W-1:0]   w_len;
  logic               w_enter_hdr0;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a handshake always beats an expiring timeout.
  always_comb begin
    w_next     = r_state;
    w_hs       = bus.in_valid & r_in_ready;
    w_counting = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_DATA);
    w_timeout  = w_counting && !w_hs && (r_to == TO_W'(TIMEOUT - 1));
    w_len      = {bus.in_data, r_len[7:0]};
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next = S_HDR0;
      end
      S_HDR0: begin
        if (w_hs)           w_next = S_HDR1;
        else if (w_timeout) w_next = S_ERR;
      end
      S_HDR1: begin
        if (w_hs) begin
          if ((w_len == '0) || ({16'd0, w_len} > DEPTH)) w_next = S_ERR;
          else                                           w_next = S_DATA;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_DATA: begin
        if (w_hs && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
        else if (w_timeout)               w_next = S_ERR;
      end
      S_WRITE: begin
        if ((r_word_cnt + 16'd1) == r_len) w_next = S_DONE;
        else                               w_next = S_DATA;
      end
      default: w_next = S_IDLE;
    endcase
    w_enter_hdr0 = (w_next == S_HDR0) && (r_state != S_HDR0);
  end

  // Registered outputs and datapath, all derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_in_ready      <= 1'b0;
      r_wr_en         <= 1'b0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
      r_cpu_reset     <= 1'b1;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
      r_words_written <= '0;
      r_len           <= '0;
      r_word_cnt      <= '0;
      r_byte_cnt      <= '0;
      r_word          <= '0;
      r_to            <= '0;
    end else begin
      r_in_ready  <= (w_next == S_HDR0) || (w_next == S_HDR1) || (w_next == S_DATA);
      r_wr_en     <= (w_next == S_WRITE);
      r_cpu_reset <= (w_next != S_DONE);
      r_done      <= (w_next == S_DONE);
      r_error     <= (w_next == S_ERR);

      if (w_counting && !w_hs && (w_next == r_state)) r_to <= r_to + TO_W'(1);
      else                                            r_to <= '0;

      if (w_enter_hdr0) begin
        r_words_written <= '0;
        r_word_cnt      <= '0;
        r_byte_cnt      <= '0;
      end

      if ((r_state == S_HDR0) && w_hs) r_len[7:0]  <= bus.in_data;
      if ((r_state == S_HDR1) && w_hs) r_len[15:8] <= bus.in_data;

      if ((r_state == S_DATA) && w_hs) begin
        r_word[{r_byte_cnt, 3'b000} +: 8] <= bus.in_data;
        r_byte_cnt                        <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == 2'd3) begin
          r_wr_data <= {bus.in_data, r_word[23:0]};
          r_wr_addr <= {14'b0, r_word_cnt, 2'b00};
        end
      end

      if (r_state == S_WRITE) begin
        r_words_written <= r_word_cnt + 16'd1;
        r_word_cnt      <= r_word_cnt + 16'd1;
        r_byte_cnt      <= '0;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign cpu_reset      = r_cpu_reset;
  assign done           = r_done;
  assign error          = r_error;
  assign words_written  = r_words_written;

endmodule
